// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared definitions for the pipeline control sequencer:
//               sequencer state encoding, default parameter values and the
//               packed control-word type with its canonical patterns.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_MEM_TIMEOUT = 64;
   localparam int WAIT_CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_RUN         = 2'd0,
      ST_MEM_WAIT    = 2'd1,
      ST_MULDIV_WAIT = 2'd2,
      ST_HALT        = 2'd3
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic ex_mem_bubble;
   } ctrl_t;

   // Normal flow: every register advances, nothing is squashed.
   function automatic ctrl_t ctrl_flow();
      ctrl_t c;
      c = '0;
      c.pc_write     = 1'b1;
      c.if_id_write  = 1'b1;
      c.id_ex_write  = 1'b1;
      c.ex_mem_write = 1'b1;
      return c;
   endfunction

   // Whole pipeline frozen in place.
   function automatic ctrl_t ctrl_freeze();
      return '0;
   endfunction

   // Front end held while EX is busy; EX/MEM keeps advancing but receives
   // a bubble so the stalled instruction does not retire twice.
   function automatic ctrl_t ctrl_muldiv_hold();
      ctrl_t c;
      c = '0;
      c.ex_mem_write  = 1'b1;
      c.ex_mem_bubble = 1'b1;
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset (clears count)
//               inc   - increment request for this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 16
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_control_sequencer
// Description : Central stall/flush controller for a 5-stage pipeline.
//               Arbitrates memory stalls, taken branches, multi-cycle
//               mul/div and load-use hazards, and halts the core when the
//               data memory fails to respond within MEM_TIMEOUT cycles.
// Ports       : i_clk, i_rst                   - clock / sync active-high reset
//               i_load_use_hazard              - ID-stage load-use hazard
//               i_branch_taken                 - taken branch/jump from EX
//               i_dmem_req, i_dmem_ready       - MEM-stage handshake
//               i_muldiv_start, i_muldiv_done  - EX multi-cycle unit
//               o_pc_write .. o_ex_mem_write   - pipeline register enables
//               o_if_id_flush, o_id_ex_bubble,
//               o_ex_mem_bubble                - control-field squash
//               o_mem_timeout                  - sticky timeout flag
//               o_stall_cycles                 - saturating PC-stall count
//               o_busy                         - sequencer not in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load_use_hazard,
   input  logic             i_branch_taken,
   input  logic             i_dmem_req,
   input  logic             i_dmem_ready,
   input  logic             i_muldiv_start,
   input  logic             i_muldiv_done,
   output logic             o_pc_write,
   output logic             o_if_id_write,
   output logic             o_id_ex_write,
   output logic             o_ex_mem_write,
   output logic             o_if_id_flush,
   output logic             o_id_ex_bubble,
   output logic             o_ex_mem_bubble,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic             o_busy
);

   // Last wait_cnt value tolerated before giving up on the memory.
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   state_t                  state;
   state_t                  state_next;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic [WAIT_CNT_W-1:0]   wait_cnt_next;
   logic                    timeout_set;
   logic                    mem_timeout;
   logic                    busy;
   logic                    mem_stall;
   logic                    muldiv_stall;
   logic                    stall_inc;
   ctrl_t                   ctrl;

   assign mem_stall    = i_dmem_req && !i_dmem_ready;
   // A start that completes in the same cycle needs no wait at all.
   assign muldiv_stall = i_muldiv_start && !i_muldiv_done;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (timeout_set) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      timeout_set   = 1'b0;
      ctrl          = ctrl_flow();
      busy          = (state != ST_RUN);

      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               ctrl          = ctrl_freeze();
               state_next    = ST_MEM_WAIT;
               wait_cnt_next = '0;
            end else if (i_branch_taken) begin
               // Squash the two wrong-path instructions behind the branch.
               ctrl.if_id_flush  = 1'b1;
               ctrl.id_ex_bubble = 1'b1;
            end else if (muldiv_stall) begin
               ctrl       = ctrl_muldiv_hold();
               state_next = ST_MULDIV_WAIT;
            end else if (i_load_use_hazard) begin
               // Hold PC and IF/ID; insert one bubble into EX.
               ctrl.pc_write     = 1'b0;
               ctrl.if_id_write  = 1'b0;
               ctrl.id_ex_bubble = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            if (i_dmem_ready) begin
               state_next    = ST_RUN;
               wait_cnt_next = '0;
            end else begin
               ctrl          = ctrl_freeze();
               wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
               if (wait_cnt == WAIT_LAST) begin
                  state_next  = ST_HALT;
                  timeout_set = 1'b1;
               end
            end
         end

         ST_MULDIV_WAIT: begin
            if (i_muldiv_done) begin
               state_next = ST_RUN;
            end else begin
               ctrl = ctrl_muldiv_hold();
            end
         end

         ST_HALT: begin
            ctrl = ctrl_freeze();
         end

         default: begin
            ctrl       = ctrl_freeze();
            state_next = ST_RUN;
         end
      endcase

      // Reset forces every enable low and hides the busy indication.
      if (i_rst) begin
         ctrl = '0;
         busy = 1'b0;
      end
   end

   assign o_pc_write      = ctrl.pc_write;
   assign o_if_id_write   = ctrl.if_id_write;
   assign o_id_ex_write   = ctrl.id_ex_write;
   assign o_ex_mem_write  = ctrl.ex_mem_write;
   assign o_if_id_flush   = ctrl.if_id_flush;
   assign o_id_ex_bubble  = ctrl.id_ex_bubble;
   assign o_ex_mem_bubble = ctrl.ex_mem_bubble;
   assign o_busy          = busy;
   assign o_mem_timeout   = mem_timeout;

   // ------------------------------------------------------------------------
   // Stall-cycle statistics
   // ------------------------------------------------------------------------
   assign stall_inc = !ctrl.pc_write;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (i_clk),
      .rst   (i_rst),
      .inc   (stall_inc),
      .count (o_stall_cycles)
   );

endmodule
`default_nettype wire
